// File: rtl/module_fsm_despliegue_pkg.sv
// Shared types and constants for the 7-segment display control path.
package pkg_despliegue;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2,
    SHOW_P = 2'd3
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_A    = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_P    = 3'b100;

  localparam int NUM_DIGITS = 3;

  // Display mux select driven for each state.
  function automatic logic [2:0] sel_of(state_t s);
    case (s)
      SHOW_A:  sel_of = SEL_A;
      SHOW_B:  sel_of = SEL_B;
      SHOW_P:  sel_of = SEL_P;
      default: sel_of = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/module_fsm_despliegue_refresh_scan.sv
// Digit scanner: refresh counter, digit rotation and active-low anode decode.
// en is the next-cycle "display active" level, so the first enabled edge
// already shows digit 0 with the counter at 0.
module module_refresh_scan
  import pkg_despliegue::*;
#(
  parameter int REFRESH_DIV = 27000,
  parameter int CNT_W       = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [NUM_DIGITS-1:0] anodo
);

  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            idx_q;
  logic [1:0]            idx_d;
  logic                  act_q;
  logic                  wrap;
  logic [NUM_DIGITS-1:0] anodo_q;

  // Next digit index: advance on counter wrap, 2 rolls back to 0.
  always_comb begin
    wrap  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    idx_d = idx_q;
    if (wrap)
      idx_d = (idx_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
  end

  // Scan registers; idle or reset blanks all digits and clears position.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= 1'b0;
      anodo_q <= '1;
    end else if (!act_q) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      act_q   <= 1'b1;
      anodo_q <= ~NUM_DIGITS'(1);
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + CNT_W'(1);
      idx_q   <= idx_d;
      anodo_q <= ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  assign anodo = anodo_q;

endmodule

// File: rtl/module_fsm_despliegue.sv
// Display control FSM: chooses A / B / product for the 7-seg mux, strobes the
// display shift register after each source change and drives the digit scan.
module module_fsm_despliegue
  import pkg_despliegue::*;
#(
  parameter int REFRESH_DIV = 27000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_load,
  input  logic       b_load,
  input  logic       mult_done,
  input  logic       clear,
  output logic [2:0] sel,
  output logic       load_disp,
  output logic [2:0] anodo,
  output logic       blank
);

  state_t     state_q, state_d;
  logic       entry;
  logic       pend_q;
  logic       ld_q;
  logic [2:0] sel_q;
  logic       blank_q;

  // Next state with priority clear > a_load > b_load > mult_done; entry
  // flags any accepted move into a showing state (re-entry of SHOW_A too).
  always_comb begin
    state_d = state_q;
    entry   = 1'b0;
    if (clear) begin
      state_d = IDLE;
    end else if (a_load) begin
      state_d = SHOW_A;
      entry   = 1'b1;
    end else if (b_load && state_q == SHOW_A) begin
      state_d = SHOW_B;
      entry   = 1'b1;
    end else if (mult_done && state_q == SHOW_B) begin
      state_d = SHOW_P;
      entry   = 1'b1;
    end
  end

  // State and registered outputs. An entry arms pend_q; the strobe fires the
  // cycle after, and is held off one cycle if it would follow another strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      blank_q <= 1'b1;
      ld_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_of(state_d);
      blank_q <= (state_d == IDLE);
      ld_q    <= pend_q & ~ld_q;
      pend_q  <= entry | (pend_q & ld_q);
    end
  end

  module_refresh_scan #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .en    (state_d != IDLE),
    .anodo (anodo)
  );

  assign sel       = sel_q;
  assign load_disp = ld_q;
  assign blank     = blank_q;

endmodule

// File: tb/tb_module_fsm_despliegue.sv
// Bench for module_fsm_despliegue with REFRESH_DIV=4: one table row per clock,
// expected outputs queued when a row is driven and checked after the edge.
module tb_module_fsm_despliegue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_load = 1'b0, b_load = 1'b0, mult_done = 1'b0, clear = 1'b0;
  logic [2:0] sel;
  logic       load_disp;
  logic [2:0] anodo;
  logic       blank;

  always #5 clk = ~clk;

  module_fsm_despliegue #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_load    (a_load),
    .b_load    (b_load),
    .mult_done (mult_done),
    .clear     (clear),
    .sel       (sel),
    .load_disp (load_disp),
    .anodo     (anodo),
    .blank     (blank)
  );

  typedef struct {
    logic       r, a, b, m, c;
    logic [2:0] sel;
    logic       ld;
    logic [2:0] an;
    logic       bl;
  } vec_t;

  typedef struct {
    int         row;
    logic [2:0] sel;
    logic       ld;
    logic [2:0] an;
    logic       bl;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic a, logic b, logic m, logic c,
                              logic [2:0] s, logic ld, logic [2:0] an, logic bl);
    vec_t v;
    v.r = r; v.a = a; v.b = b; v.m = m; v.c = c;
    v.sel = s; v.ld = ld; v.an = an; v.bl = bl;
    tbl.push_back(v);
  endfunction

  // Idle: nothing shown.
  function automatic void add_idle(logic r, logic a, logic b, logic m, logic c);
    add(r, a, b, m, c, 3'b000, 1'b0, 3'b111, 1'b1);
  endfunction

  initial begin
    exp_t e;
    logic prev_ld;

    // reset held 3 cycles, then ignored events in IDLE, then 50 quiet cycles
    for (int i = 0; i < 3; i++) add_idle(1, 0, 0, 0, 0);
    add_idle(0, 0, 1, 0, 0);
    add_idle(0, 0, 0, 1, 0);
    add_idle(0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) add_idle(0, 0, 0, 0, 0);

    // A -> B -> P with ignored events and a full digit rotation
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b110, 0);
    add(0, 0, 0, 1, 0, 3'b001, 0, 3'b110, 0);  // mult_done in SHOW_A
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 1, 0, 0, 3'b010, 0, 3'b101, 0);
    add(0, 0, 0, 0, 0, 3'b010, 1, 3'b101, 0);
    add(0, 0, 1, 0, 0, 3'b010, 0, 3'b101, 0);  // b_load in SHOW_B
    add(0, 0, 0, 0, 0, 3'b010, 0, 3'b101, 0);
    add(0, 0, 0, 1, 0, 3'b100, 0, 3'b011, 0);
    add(0, 0, 0, 0, 0, 3'b100, 1, 3'b011, 0);
    add(0, 0, 1, 0, 0, 3'b100, 0, 3'b011, 0);  // b_load in SHOW_P
    add(0, 0, 0, 1, 0, 3'b100, 0, 3'b011, 0);  // mult_done in SHOW_P
    add(0, 0, 0, 0, 0, 3'b100, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b100, 0, 3'b110, 0);
    add_idle(0, 1, 0, 0, 1);                    // clear beats a_load
    add_idle(0, 0, 0, 0, 0);

    // re-entry of SHOW_A: a_load+b_load together, and a_load on the pulse cycle
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 1, 1, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b101, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b101, 0);
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b101, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b101, 0);
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b011, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b011, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b011, 0);
    add_idle(0, 0, 0, 0, 1);
    add_idle(0, 0, 0, 0, 0);

    // reset mid-scan in SHOW_B (anodo=101), then restart from scratch
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b110, 0);
    add(0, 0, 1, 0, 0, 3'b010, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b010, 1, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b010, 0, 3'b101, 0);
    add_idle(1, 0, 0, 0, 0);
    add_idle(0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 1, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b110, 0);
    add(0, 0, 0, 0, 0, 3'b001, 0, 3'b101, 0);

    prev_ld = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; a_load = tbl[i].a; b_load = tbl[i].b;
      mult_done = tbl[i].m; clear = tbl[i].c;
      e.row = i; e.sel = tbl[i].sel; e.ld = tbl[i].ld;
      e.an = tbl[i].an; e.bl = tbl[i].bl;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (sel !== e.sel || load_disp !== e.ld || anodo !== e.an || blank !== e.bl) begin
        errors++;
        $display("FAIL row%0d: got sel=%b ld=%b anodo=%b blank=%b, want sel=%b ld=%b anodo=%b blank=%b",
                 e.row, sel, load_disp, anodo, blank, e.sel, e.ld, e.an, e.bl);
      end
      checks++;
      if (prev_ld === 1'b1 && load_disp === 1'b1) begin
        errors++;
        $display("FAIL ld_consec row%0d: got load_disp=1 twice in a row, want at most one", i);
      end
      prev_ld = load_disp;
    end

    @(negedge clk);
    a_load = 0; b_load = 0; mult_done = 0; clear = 0; rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
